// File: rtl/kb_pkg.sv
// Shared definitions for the 4x4 keypad matrix scanner.
// Contents: matrix geometry, KB code field layout, FSM state encoding and a
// snapshot decoder that reports "exactly one key down" plus that key's index.
package kb_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int COL_W    = $clog2(NUM_COLS);

  // KB code: [7:4] always zero, [3:0] = col*4 + row
  localparam int KB_W     = 8;
  localparam int KB_IDX_W = 4;
  localparam int KB_PAD_W = KB_W - KB_IDX_W;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } kb_state_e;

  typedef struct packed {
    logic                one_hot;
    logic [KB_IDX_W-1:0] idx;
  } key_decode_t;

  // idx is only meaningful when one_hot is set
  function automatic key_decode_t decode_keys(input logic [NUM_KEYS-1:0] snap);
    key_decode_t res;
    int unsigned cnt;
    res = '0;
    cnt = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (snap[i]) begin
        cnt++;
        res.idx = KB_IDX_W'(i);
      end
    end
    res.one_hot = (cnt == 1);
    return res;
  endfunction

endpackage

// File: rtl/kb_matrix_scanner_timer.sv
// Column scan timer for the keypad matrix.
// Drives one column low at a time for SCAN_DIV cycles each, cycling 0..3.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   col_idx       : column currently driven
//   col_out       : active-low one-hot column drive (registered)
//   sample_stb    : last dwell cycle of the current column
//   scan_end_stb  : last dwell cycle of the last column (end of full scan)
module kb_scan_timer
  import kb_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [COL_W-1:0] col_idx,
  output logic [3:0]       col_out,
  output logic             sample_stb,
  output logic             scan_end_stb
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS - 1);

  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [3:0]       col_out_q, col_out_d;

  always_comb begin
    dwell_d   = dwell_q + 1'b1;
    col_d     = col_q;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end
    // registered so the drive changes in the same edge as col_q
    col_out_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_q   <= '0;
      col_q     <= '0;
      col_out_q <= 4'b1110;
    end else begin
      dwell_q   <= dwell_d;
      col_q     <= col_d;
      col_out_q <= col_out_d;
    end
  end

  assign col_idx      = col_q;
  assign col_out      = col_out_q;
  assign sample_stb   = (dwell_q == DWELL_LAST);
  assign scan_end_stb = sample_stb && (col_q == COL_LAST);

endmodule

// File: rtl/kb_matrix_scanner.sv
// 4x4 active-low keypad scanner with debounce and valid/ack key-code output.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   row_in     : keypad rows, active-low, asynchronous
//   col_out    : keypad column drive, active-low one-hot
//   kb_ack     : consumer has taken KB
//   KB         : key code {4'b0, col*4+row}
//   kb_valid   : KB holds an unconsumed code
//   kb_overrun : sticky, an unacked code was overwritten
module kb_matrix_scanner
  import kb_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      row_in,
  output logic [3:0]      col_out,
  input  logic            kb_ack,
  output logic [KB_W-1:0] KB,
  output logic            kb_valid,
  output logic            kb_overrun
);

  localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] DEB_M1  = 4'(DEBOUNCE_SCANS - 1);

  logic [COL_W-1:0] col_idx;
  logic             sample_stb;
  logic             scan_end_stb;

  kb_scan_timer #(
    .SCAN_DIV(SCAN_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .col_idx     (col_idx),
    .col_out     (col_out),
    .sample_stb  (sample_stb),
    .scan_end_stb(scan_end_stb)
  );

  logic [3:0]          sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] snap_q, snap_d, snap_full;
  logic [NUM_KEYS-1:0] prev_snap_q, prev_snap_d;
  logic [3:0]          stable_cnt_q, stable_cnt_d;
  logic                evt_q, evt_d;
  kb_state_e           state_q, state_d;
  logic [KB_IDX_W-1:0] kb_idx_q, kb_idx_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                emit;
  key_decode_t         dec;

  // Working snapshot with the current column's sample merged in, so the
  // end-of-scan compare already sees column 3 of this scan.
  always_comb begin
    snap_full = snap_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      snap_full[{col_idx, ROW_W'(r)}] = ~sync2_q[r];
    end
    snap_d = sample_stb ? snap_full : snap_q;
  end

  // Debounce: stable event pulses once, on the scan where the count of
  // consecutive identical snapshots first reaches DEBOUNCE_SCANS.
  always_comb begin
    prev_snap_d  = prev_snap_q;
    stable_cnt_d = stable_cnt_q;
    evt_d        = 1'b0;
    if (scan_end_stb) begin
      if (snap_full == prev_snap_q) begin
        if (stable_cnt_q != DEB_CNT) begin
          stable_cnt_d = stable_cnt_q + 1'b1;
        end
        evt_d = (stable_cnt_q == DEB_M1);
      end else begin
        prev_snap_d  = snap_full;
        stable_cnt_d = 4'd1;
        evt_d        = (DEB_CNT == 4'd1);
      end
    end
  end

  // prev_snap_q holds the stable snapshot while evt_q is high
  assign dec = decode_keys(prev_snap_q);

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    if (evt_q) begin
      if (state_q == IDLE) begin
        if (dec.one_hot) begin
          emit    = 1'b1;
          state_d = HELD;
        end
      end else if (prev_snap_q == '0) begin
        state_d = IDLE;
      end
    end
  end

  // A new code always wins over a same-cycle ack; overrun only when the
  // previous code is still unacked.
  always_comb begin
    kb_idx_d  = kb_idx_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (emit) begin
      kb_idx_d = dec.idx;
      valid_d  = 1'b1;
      if (valid_q && !kb_ack) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && kb_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 4'hF;
      sync2_q      <= 4'hF;
      snap_q       <= '0;
      prev_snap_q  <= '0;
      stable_cnt_q <= '0;
      evt_q        <= 1'b0;
      state_q      <= IDLE;
      kb_idx_q     <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= row_in;
      sync2_q      <= sync1_q;
      snap_q       <= snap_d;
      prev_snap_q  <= prev_snap_d;
      stable_cnt_q <= stable_cnt_d;
      evt_q        <= evt_d;
      state_q      <= state_d;
      kb_idx_q     <= kb_idx_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign KB         = {KB_PAD_W'(0), kb_idx_q};
  assign kb_valid   = valid_q;
  assign kb_overrun = overrun_q;

endmodule
